// File: rtl/fpnew_pkg.sv
// Shared types for the FPU result buffer: exception flags and the stored
// result entry. Entry fields are sized for the widest supported
// configuration; instances with narrower Width/TagWidth use the low bits.
package fpnew_pkg;

  localparam int unsigned EntryWidth    = 64;
  localparam int unsigned EntryTagWidth = 8;

  // IEEE 754 exception flags, in the usual NV/DZ/OF/UF/NX order (MSB first).
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic [EntryWidth-1:0]    result;
    status_t                  status;
    logic [EntryTagWidth-1:0] tag;
  } result_entry_t;

endpackage

// File: rtl/fpnew_flag_acc.sv
// Sticky exception-flag accumulator for fpnew_result_buffer.
// Only present when FPNEW_RESULT_FLAGS_ACC_EN is defined; the buffer ties
// its flags output to zero otherwise.
`ifdef FPNEW_RESULT_FLAGS_ACC_EN
module fpnew_flag_acc
  import fpnew_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    clr_i,
  input  status_t status_i,
  output status_t flags_o
);

  status_t flags_q, flags_d;

  // Clear first, then OR in an accepted result, so clear+push leaves just the new flags.
  always_comb begin
    // NOTE: default assignment first so every path writes flags_d (no latch).
    flags_d = flags_q;
    if (clr_i) flags_d = '0;
    if (push_i) flags_d = status_t'(flags_d | status_i);
  end

  // Flag register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for state so all registers update together.
    if (rst_i) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule
`endif

// File: rtl/fpnew_result_buffer.sv
// Result buffer behind the FPU wrapper: a circular FIFO that absorbs
// one-cycle result pulses which cannot be back-pressured. A result arriving
// while the buffer is full (and nothing leaves) is lost and recorded in the
// sticky drop_o. Define FPNEW_RESULT_FLAGS_ACC_EN to accumulate exception
// flags of accepted results on flags_o; otherwise flags_o is 0.
module fpnew_result_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = 4,
  parameter int unsigned TagWidth = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [Width-1:0]           in_result_i,
  input  status_t                    in_status_i,
  input  logic [TagWidth-1:0]        in_tag_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           out_result_o,
  output status_t                    out_status_o,
  output logic [TagWidth-1:0]        out_tag_o,
  output logic [$clog2(Depth):0]     usage_o,
  output logic                       drop_o,
  output status_t                    flags_o,
  input  logic                       flags_clr_i
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  result_entry_t         mem_q [Depth];
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic                  full, pop, push, accept;
  result_entry_t         wr_entry, head;

  // Handshake decode: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    full   = (cnt_q == DepthCnt);
    pop    = (cnt_q != '0) && out_ready_i;
    push   = in_valid_i && (!full || pop);
    accept = push && !flush_i;
  end

  // Next-state for pointers, count and the sticky drop flag; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q | (in_valid_i & full & ~pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Pack the incoming result into a storage entry.
  always_comb begin
    wr_entry        = '0;
    wr_entry.result = EntryWidth'(in_result_i);
    wr_entry.status = in_status_i;
    wr_entry.tag    = EntryTagWidth'(in_tag_i);
  end

  // Entry storage written at the write pointer on each accepted push.
  always_ff @(posedge clk_i) begin
    // NOTE: storage has no reset; the count alone decides which entries are valid.
    if (accept) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign out_valid_o  = (cnt_q != '0);
  assign out_result_o = head.result[Width-1:0];
  assign out_status_o = head.status;
  assign out_tag_o    = head.tag[TagWidth-1:0];
  assign in_ready_o   = !full;
  assign usage_o      = cnt_q;
  assign drop_o       = drop_q;

  // Upper entry bits are unused when Width/TagWidth are below the entry size.
  logic unused_head;
  assign unused_head = ^head;

`ifdef FPNEW_RESULT_FLAGS_ACC_EN
  fpnew_flag_acc u_flag_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (accept),
    .clr_i    (flags_clr_i),
    .status_i (in_status_i),
    .flags_o  (flags_o)
  );
`else
  assign flags_o = '0;
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr_i;
`endif

endmodule

// File: doc/fpnew_result_buffer.md
FPNEW_RESULT_BUFFER -- requirements
Module: fpnew_result_buffer

Interface
REQ-001 SHALL have parameter Width, default 64: result data width in bits.
REQ-002 SHALL have parameter Depth, default 4: number of result entries, a power of two, at least 2.
REQ-003 SHALL have parameter TagWidth, default 1: width of the tag.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 flush_i  in  1  discard all buffered entries.
REQ-007 in_valid_i  in  1  one-cycle result pulse from the FPU wrapper; cannot be back-pressured.
REQ-008 in_result_i  in  Width  result data.
REQ-009 in_status_i  in  fpnew_pkg::status_t (5)  exception flags NV/DZ/OF/UF/NX.
REQ-010 in_tag_i  in  TagWidth  tag.
REQ-011 in_ready_o  out  1  advisory: 1 when at least one entry is free.
REQ-012 out_valid_o, out_ready_i  out/in  1 each  output handshake.
REQ-013 out_result_o, out_status_o, out_tag_o  out  Width/5/TagWidth  head entry.
REQ-014 usage_o  out  $clog2(Depth)+1  number of occupied entries.
REQ-015 drop_o  out  1  sticky: a result was lost because the buffer was full.
REQ-016 flags_o  out  5; flags_clr_i  in  1  sticky accumulated flags and their clear (REQ-031).

Function
REQ-017 SHALL store entries as a circular FIFO with read pointer, write pointer and count.
- No fall-through: an entry pushed in cycle N is first presented in cycle N+1.
REQ-018 SHALL accept (push) when in_valid_i=1 and either count<Depth or a pop occurs in the same cycle.
REQ-019 SHALL pop when out_valid_o=1 and out_ready_i=1.
REQ-020 SHALL drive out_valid_o = (count!=0).
- out_* SHALL be the head entry.
- out_* SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-021 On in_valid_i=1 with count=Depth and no pop, SHALL discard the input and set drop_o=1.
- drop_o SHALL stay set until reset.
REQ-022 Simultaneous push and pop SHALL leave count unchanged at every occupancy from 1 to Depth.
REQ-023 Pointers SHALL wrap modulo Depth.
REQ-024 usage_o SHALL equal count.
REQ-025 in_ready_o SHALL equal (count<Depth).
REQ-026 flush_i SHALL set count and both pointers to 0 in the next cycle, overriding a same-cycle push or pop.
- flush_i SHALL NOT clear drop_o or flags_o.
REQ-027 Entries SHALL be delivered in arrival order; no entry is duplicated or reordered.

Reset
REQ-028 rst_i=1 SHALL set count, both pointers, drop_o and flags_o to 0.
- Therefore out_valid_o=0 and in_ready_o=1.
REQ-029 Reset mid-operation SHALL discard all entries; an in_valid_i pulse in the reset cycle SHALL be ignored.
REQ-030 Storage array contents SHALL NOT be reset.

Configuration
REQ-031 With FPNEW_RESULT_FLAGS_ACC_EN defined, flags_o SHALL accumulate as follows:
- Each accepted push SHALL OR in_status_i into flags_o.
- flags_clr_i=1 SHALL clear flags_o.
- Same-cycle clear and push SHALL yield flags_o = in_status_i.
- Dropped inputs SHALL NOT contribute.
REQ-032 Without FPNEW_RESULT_FLAGS_ACC_EN, flags_o SHALL be constant 0 and flags_clr_i SHALL be ignored.

Structure
REQ-033 status_t and a result_entry_t struct {result, status, tag} SHALL live in fpnew_pkg.
REQ-034 The flag accumulator SHALL be the single sub-module fpnew_flag_acc, instantiated only under the macro.
- Storage and control SHALL be inline.

Verification
REQ-035 Reset, then in_valid_i with result 0x3FF0000000000000, status 0, tag 1 -> next cycle out_valid_o=1, out_result_o=0x3FF0000000000000, out_tag_o=1, usage_o=1.
REQ-036 Depth=4, out_ready_i=0, 5 pulses with tags 0..4 -> usage_o=4, drop_o=1; then drain with out_ready_i=1 -> tags 0,1,2,3 in order.
REQ-037 Full buffer, in_valid_i and out_ready_i both 1 in the same cycle -> no drop, usage_o stays 4, the new tag appears last.
REQ-038 3 entries buffered, flush_i=1 together with an in_valid_i pulse -> next cycle usage_o=0, out_valid_o=0; drop_o and flags_o unchanged.
REQ-039 Macro on: pushes with status 0x01 then 0x10 -> flags_o=0x11; flags_clr_i together with a push of status 0x04 -> flags_o=0x04.
REQ-040 Assert rst_i with 2 entries and drop_o=1 -> next cycle usage_o=0, drop_o=0, flags_o=0, in_ready_o=1.
